// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared states, CSR offsets and status layout for the I/O bus controller
package io_bus_pkg;

   typedef enum logic [1:0] {IDLE, ACTIVE, CSR, ERR} state_t;

   localparam int CSR_STATUS = 0;
   localparam int CSR_COUNT  = 1;

   localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

   localparam int ST_VALID_BIT = 31;
   localparam int ST_WE_BIT    = 30;
   localparam int ST_OVF_BIT   = 29;
   localparam int ST_ADDR_W    = 22;

   // Word-0 status: {valid, fault_we, overflow, 7'b0, fault_addr[23:2]}
   function automatic logic [31:0] pack_status(input logic valid, input logic fault_we,
                                               input logic overflow,
                                               input logic [ST_ADDR_W-1:0] fault_addr);
      logic [31:0] w;
      w = '0;
      w[ST_VALID_BIT] = valid;
      w[ST_WE_BIT] = fault_we;
      w[ST_OVF_BIT] = overflow;
      w[ST_ADDR_W-1:0] = fault_addr;
      return w;
   endfunction

endpackage

// File: rtl/io_bus_if.sv
// rtl/io_bus_if.sv - CPU-side and peripheral-side signals of the I/O region
interface io_bus_if #(
   parameter int NUM_SLV = 7
) ();
   logic                   stb;
   logic                   we;
   logic [23:2]            addr;
   logic [31:0]            data_in;
   logic [31:0]            data_out;
   logic                   ack;
   logic                   sel;
   logic                   irq;
   logic [NUM_SLV-1:0]     slv_stb;
   logic [NUM_SLV-1:0]     slv_ack;
   logic [32*NUM_SLV-1:0]  slv_dout;

   modport master (
      output stb, we, addr, data_in, slv_ack, slv_dout,
      input  data_out, ack, sel, irq, slv_stb
   );

   modport slave (
      input  stb, we, addr, data_in, slv_ack, slv_dout,
      output data_out, ack, sel, irq, slv_stb
   );
endinterface

// File: rtl/io_bus_fault.sv
// rtl/io_bus_fault.sv - bus-timeout fault status: first faulting address, overflow and count
module io_bus_fault (
   input  logic        clk,
   input  logic        rst,
   input  logic        record,
   input  logic [23:2] rec_addr,
   input  logic        rec_we,
   input  logic        clr_status,
   input  logic        clr_cnt,
   output logic        valid,
   output logic        overflow,
   output logic        fault_we,
   output logic [23:2] fault_addr,
   output logic [15:0] fault_cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid      <= 1'b0;
         overflow   <= 1'b0;
         fault_we   <= 1'b0;
         fault_addr <= '0;
         fault_cnt  <= '0;
      end else begin
         // Only the first fault keeps its address; later ones just flag overflow
         if (record) begin
            if (!valid) begin
               valid      <= 1'b1;
               fault_addr <= rec_addr;
               fault_we   <= rec_we;
            end else begin
               overflow <= 1'b1;
            end
            if (fault_cnt != 16'hFFFF) fault_cnt <= fault_cnt + 16'd1;
         end
         if (clr_status) begin
            valid      <= 1'b0;
            overflow   <= 1'b0;
            fault_we   <= 1'b0;
            fault_addr <= '0;
         end
         if (clr_cnt) fault_cnt <= '0;
      end
   end

endmodule

// File: rtl/io_bus_ctrl.sv
// rtl/io_bus_ctrl.sv - I/O window decoder, slave strobe/ack forwarding and bus timeout
module io_bus_ctrl
   import io_bus_pkg::*;
#(
   parameter int          IDX_W      = 3,
   parameter int          SLOT_LOG2  = 1,
   parameter int          NUM_SLV    = 7,
   parameter logic [23:2] BASE       = 22'h3FFFE0,
   parameter int          TMO_CYCLES = 255
) (
   input logic      clk,
   input logic      rst,
   io_bus_if.slave  bus
);

   localparam int DEC_LO = IDX_W + SLOT_LOG2 + 2;
   localparam logic [15:0] TMO_LIMIT = 16'(TMO_CYCLES);

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     idx_q;
   logic [SLOT_LOG2-1:0] word_q;
   logic                 we_q;
   logic [23:2]          addr_q;
   logic [15:0]          count, count_nxt, count_inc;

   logic                 sel;
   logic [IDX_W-1:0]     dec_idx;
   logic [SLOT_LOG2-1:0] dec_word;
   logic                 hit_ack;
   logic [31:0]          hit_dout;
   logic [NUM_SLV-1:0]   stb_vec;
   logic [NUM_SLV-1:0]   slv_stb;
   logic                 ack;
   logic [31:0]          rdata;
   logic [31:0]          csr_rdata;
   logic                 record, clr_status, clr_cnt;
   logic                 valid, overflow, fault_we;
   logic [23:2]          fault_addr;
   logic [15:0]          fault_cnt;
   logic                 unused_data_in;

   // Slaves latch write data straight off the CPU bus; CSR writes only need the strobe
   assign unused_data_in = ^bus.data_in;

   assign sel       = bus.stb && (bus.addr[23:DEC_LO] == BASE[23:DEC_LO]);
   assign dec_idx   = bus.addr[DEC_LO-1:SLOT_LOG2+2];
   assign dec_word  = bus.addr[SLOT_LOG2+1:2];
   assign count_inc = count + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         idx_q  <= '0;
         word_q <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (state == IDLE && sel) begin
            idx_q  <= dec_idx;
            word_q <= dec_word;
            we_q   <= bus.we;
            addr_q <= bus.addr;
         end
      end
   end

   always_comb begin
      hit_ack  = 1'b0;
      hit_dout = '0;
      stb_vec  = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx_q == IDX_W'(i)) begin
            hit_ack    = bus.slv_ack[i];
            hit_dout   = bus.slv_dout[32*i +: 32];
            stb_vec[i] = 1'b1;
         end
      end
   end

   always_comb begin
      csr_rdata = '0;
      if (word_q == SLOT_LOG2'(CSR_STATUS))
         csr_rdata = pack_status(valid, fault_we, overflow, fault_addr);
      else if (word_q == SLOT_LOG2'(CSR_COUNT))
         csr_rdata = {16'b0, fault_cnt};
   end

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      ack        = 1'b0;
      rdata      = '0;
      slv_stb    = '0;
      record     = 1'b0;
      clr_status = 1'b0;
      clr_cnt    = 1'b0;
      case (state)
         IDLE: begin
            if (sel) begin
               if (int'(dec_idx) < NUM_SLV) begin
                  state_nxt = ACTIVE;
                  count_nxt = '0;
               end else if (int'(dec_idx) == NUM_SLV) begin
                  state_nxt = CSR;
               end else begin
                  state_nxt = ERR;
               end
            end
         end
         ACTIVE: begin
            if (!bus.stb) begin
               state_nxt = IDLE;
            end else begin
               slv_stb = stb_vec;
               // An ack arriving on the timeout cycle still completes normally
               if (hit_ack) begin
                  ack       = 1'b1;
                  rdata     = hit_dout;
                  state_nxt = IDLE;
               end else begin
                  count_nxt = count_inc;
                  if (count_inc == TMO_LIMIT) state_nxt = ERR;
               end
            end
         end
         CSR: begin
            state_nxt = IDLE;
            if (bus.stb) begin
               ack   = 1'b1;
               rdata = csr_rdata;
               if (we_q) begin
                  clr_status = (word_q == SLOT_LOG2'(CSR_STATUS));
                  clr_cnt    = (word_q == SLOT_LOG2'(CSR_COUNT));
               end
            end
         end
         ERR: begin
            state_nxt = IDLE;
            if (bus.stb) begin
               ack    = 1'b1;
               rdata  = ERR_DATA;
               record = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   io_bus_fault u_fault (
      .clk        (clk),
      .rst        (rst),
      .record     (record),
      .rec_addr   (addr_q),
      .rec_we     (we_q),
      .clr_status (clr_status),
      .clr_cnt    (clr_cnt),
      .valid      (valid),
      .overflow   (overflow),
      .fault_we   (fault_we),
      .fault_addr (fault_addr),
      .fault_cnt  (fault_cnt)
   );

   assign bus.sel      = sel;
   assign bus.ack      = ack;
   assign bus.data_out = rdata;
   assign bus.slv_stb  = slv_stb;
   assign bus.irq      = valid;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb/tb_io_bus_ctrl.sv - scoreboard bench for io_bus_ctrl with 6 slaves and an 8-cycle timeout
module tb_io_bus_ctrl;
   import io_bus_pkg::*;

   localparam int NS = 6;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      bit          chk_data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   start_cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   exp_t e_mon;
   logic [NS-1:0] stb_at_ack;

   logic [31:0] slave_data [NS];
   logic [2:0]  ack_slave;
   logic [15:0] ack_wait;
   bit          ack_en;
   logic [2:0]  rogue_slave;
   bit          rogue_en;
   logic [15:0] stb_cycles;

   io_bus_if #(.NUM_SLV(NS)) bus ();

   io_bus_ctrl #(
      .IDX_W(3), .SLOT_LOG2(1), .NUM_SLV(NS), .BASE(22'h3FFFE0), .TMO_CYCLES(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: chosen slave acks after ack_wait strobed cycles; a rogue slave may ack unasked
   always @(posedge clk or posedge rst) begin
      if (rst) stb_cycles <= '0;
      else if (bus.slv_stb != '0) stb_cycles <= stb_cycles + 16'd1;
      else stb_cycles <= '0;
   end

   always_comb begin
      bus.slv_ack = '0;
      bus.slv_dout = '0;
      if (ack_en && bus.slv_stb[ack_slave] && stb_cycles == ack_wait) bus.slv_ack[ack_slave] = 1'b1;
      if (rogue_en) bus.slv_ack[rogue_slave] = 1'b1;
      for (int i = 0; i < NS; i++) bus.slv_dout[32*i +: 32] = slave_data[i];
   end

   // Scoreboard monitor: each ack pops one expectation; idle data must be zero
   always @(negedge clk) begin
      if (!rst && bus.ack) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_ack: got ack at addr %h, want no ack", bus.addr);
         end else begin
            e_mon = sb.pop_front();
            if ((cyc - start_cyc) !== e_mon.cyc) begin
               miscompares++;
               $display("FAIL ack_cycle addr %h: got cycle %0d, want %0d", bus.addr, cyc - start_cyc, e_mon.cyc);
            end
            if (e_mon.chk_data) begin
               vectors++;
               if (bus.data_out !== e_mon.data) begin
                  miscompares++;
                  $display("FAIL read_data addr %h: got %h, want %h", bus.addr, bus.data_out, e_mon.data);
               end
            end
         end
      end else if (!bus.ack) begin
         vectors++;
         if (bus.data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_data: got %h, want 00000000", bus.data_out);
         end
      end
   end

   task automatic bus_cycle(input logic [23:2] a, input logic w, input logic [31:0] wd,
                            input int exp_cyc, input logic [31:0] exp_data, input bit chk);
      exp_t e;
      bit got;
      e.cyc = exp_cyc;
      e.data = exp_data;
      e.chk_data = chk;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.stb = 1'b1; bus.we = w; bus.addr = a; bus.data_in = wd;
      start_cyc = cyc;
      got = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.ack) begin
            got = 1'b1;
            stb_at_ack = bus.slv_stb;
            break;
         end
      end
      if (!got) begin
         vectors++; miscompares++;
         $display("FAIL ack_wait addr %h: got no ack in 40 cycles, want ack", a);
         sb.delete();
      end
      @(posedge clk); #1;
      bus.stb = 1'b0; bus.we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++; if (bus.ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %b want 0", bus.ack); end
      vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq: got %b want 0", bus.irq); end
      vectors++; if (bus.slv_stb !== '0) begin miscompares++; $display("FAIL rst_slv_stb: got %b want 0", bus.slv_stb); end
      vectors++; if (bus.data_out !== 32'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0", bus.data_out); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_zero_wait();
      slave_data[2] = 32'h1234_5678;
      slave_data[3] = 32'hDEAD_BEEF;
      ack_en = 1'b1; ack_slave = 3'd2; ack_wait = 16'd0;
      rogue_en = 1'b1; rogue_slave = 3'd3;
      bus_cycle(22'h3FFFE4, 1'b0, 32'h0, 1, 32'h1234_5678, 1'b1);
      vectors++; if (stb_at_ack !== 6'b000100) begin miscompares++; $display("FAIL zw_onehot: got %b want 000100", stb_at_ack); end
      rogue_en = 1'b0;
   endtask

   task automatic test_wait_states();
      slave_data[5] = 32'h5A5A_0005;
      ack_en = 1'b1; ack_slave = 3'd5; ack_wait = 16'd3;
      bus_cycle(22'h3FFFEA, 1'b0, 32'h0, 4, 32'h5A5A_0005, 1'b1);
      vectors++; if (stb_at_ack !== 6'b100000) begin miscompares++; $display("FAIL ws_onehot: got %b want 100000", stb_at_ack); end
      vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL ws_irq: got %b want 0", bus.irq); end
      bus_cycle(22'h3FFFED, 1'b0, 32'h0, 1, 32'h0, 1'b1);
   endtask

   task automatic test_timeout();
      ack_en = 1'b0;
      bus_cycle(22'h3FFFE2, 1'b0, 32'h0, 9, ERR_DATA, 1'b1);
      vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL tmo_irq: got %b want 1", bus.irq); end
      bus_cycle(22'h3FFFEC, 1'b0, 32'h0, 1, 32'h803F_FFE2, 1'b1);
      bus_cycle(22'h3FFFED, 1'b0, 32'h0, 1, 32'h0000_0001, 1'b1);
   endtask

   task automatic test_overflow();
      ack_en = 1'b0;
      bus_cycle(22'h3FFFE6, 1'b1, 32'h0000_CAFE, 9, ERR_DATA, 1'b1);
      bus_cycle(22'h3FFFEC, 1'b0, 32'h0, 1, 32'hA03F_FFE2, 1'b1);
      bus_cycle(22'h3FFFED, 1'b0, 32'h0, 1, 32'h0000_0002, 1'b1);
      bus_cycle(22'h3FFFEC, 1'b1, 32'h0, 1, 32'h0, 1'b0);
      vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL ovf_clr_irq: got %b want 0", bus.irq); end
      bus_cycle(22'h3FFFEC, 1'b0, 32'h0, 1, 32'h0, 1'b1);
      bus_cycle(22'h3FFFED, 1'b0, 32'h0, 1, 32'h0000_0002, 1'b1);
      bus_cycle(22'h3FFFED, 1'b1, 32'h0, 1, 32'h0, 1'b0);
      bus_cycle(22'h3FFFED, 1'b0, 32'h0, 1, 32'h0, 1'b1);
   endtask

   task automatic test_unmapped();
      logic [23:2] outside [2];
      outside[0] = 22'h3FFFDF;
      outside[1] = 22'h3FFFF0;
      bus_cycle(22'h3FFFEE, 1'b0, 32'h0, 1, ERR_DATA, 1'b1);
      vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL unm_irq: got %b want 1", bus.irq); end
      bus_cycle(22'h3FFFEC, 1'b0, 32'h0, 1, 32'h803F_FFEE, 1'b1);
      @(posedge clk); #1;
      bus.stb = 1'b1; bus.addr = 22'h3FFFE0;
      #1;
      vectors++; if (bus.sel !== 1'b1) begin miscompares++; $display("FAIL sel_hit: got %b want 1", bus.sel); end
      bus.stb = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         bus.stb = 1'b1; bus.addr = outside[k];
         repeat (4) begin
            @(negedge clk);
            vectors++;
            if ({bus.sel, bus.slv_stb, bus.ack} !== '0) begin
               miscompares++;
               $display("FAIL outside %h: got sel/stb/ack %b, want 0", outside[k], {bus.sel, bus.slv_stb, bus.ack});
            end
         end
         bus.stb = 1'b0;
      end
      bus_cycle(22'h3FFFEC, 1'b1, 32'h0, 1, 32'h0, 1'b0);
      bus_cycle(22'h3FFFED, 1'b1, 32'h0, 1, 32'h0, 1'b0);
   endtask

   task automatic test_reset_mid();
      ack_en = 1'b0;
      @(posedge clk); #1;
      bus.stb = 1'b1; bus.we = 1'b0; bus.addr = 22'h3FFFE2;
      repeat (5) @(posedge clk);
      #1;
      vectors++; if (bus.slv_stb !== 6'b000010) begin miscompares++; $display("FAIL mid_active: got %b want 000010", bus.slv_stb); end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({bus.ack, bus.irq, bus.slv_stb, bus.data_out} !== '0) begin
         miscompares++;
         $display("FAIL mid_rst_outputs: got ack %b irq %b stb %b data %h, want all 0", bus.ack, bus.irq, bus.slv_stb, bus.data_out);
      end
      bus.stb = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      ack_en = 1'b1; ack_slave = 3'd2; ack_wait = 16'd0;
      bus_cycle(22'h3FFFE4, 1'b0, 32'h0, 1, 32'h1234_5678, 1'b1);
   endtask

   task automatic test_stb_drop();
      ack_en = 1'b0;
      @(posedge clk); #1;
      bus.stb = 1'b1; bus.addr = 22'h3FFFE8;
      repeat (3) @(posedge clk);
      #1 bus.stb = 1'b0;
      @(negedge clk);
      vectors++; if (bus.slv_stb !== '0) begin miscompares++; $display("FAIL drop_stb: got %b want 0", bus.slv_stb); end
      repeat (12) @(negedge clk);
      vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL drop_irq: got %b want 0", bus.irq); end
      bus_cycle(22'h3FFFED, 1'b0, 32'h0, 1, 32'h0, 1'b1);
   endtask

   task automatic test_back_to_back();
      slave_data[0] = 32'h0BAD_F00D;
      ack_en = 1'b1; ack_slave = 3'd0; ack_wait = 16'd1;
      bus_cycle(22'h3FFFE1, 1'b0, 32'h0, 2, 32'h0BAD_F00D, 1'b1);
      bus_cycle(22'h3FFFE0, 1'b1, 32'h1111_2222, 2, 32'h0BAD_F00D, 1'b1);
      bus_cycle(22'h3FFFEC, 1'b0, 32'h0, 1, 32'h0, 1'b1);
      ack_slave = 3'd4; ack_wait = 16'd7;
      slave_data[4] = 32'h4444_0004;
      bus_cycle(22'h3FFFE8, 1'b0, 32'h0, 8, 32'h4444_0004, 1'b1);
      vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL b2b_edge_irq: got %b want 0", bus.irq); end
   endtask

   initial begin
      rst = 1'b1;
      bus.stb = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
      ack_en = 1'b0; ack_slave = '0; ack_wait = '0; rogue_en = 1'b0; rogue_slave = '0;
      for (int i = 0; i < NS; i++) slave_data[i] = 32'hA000_0000 + i;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_timeout();
      test_overflow();
      test_unmapped();
      test_reset_mid();
      test_stb_drop();
      test_back_to_back();
      repeat (3) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 ns, want finish");
      $fatal(1, "watchdog");
   end

endmodule
